// File: rtl/rf_wb_pkg.sv
// Shared types and constants for the register-file writeback stage.
// The load entry carries raw memory data; alignment happens when the entry leaves the buffer.
package rf_wb_pkg;

  localparam int WB_XLEN = 32;
  localparam int REG_CNT = 32;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LH  = 3'd1,
    LW  = 3'd2,
    LBU = 3'd4,
    LHU = 3'd5
  } ld_funct3_e;

  typedef struct packed {
    logic [4:0]         rd;
    logic [WB_XLEN-1:0] data;
    logic [2:0]         funct3;
    logic [1:0]         addr_lo;
  } ld_entry_t;

endpackage

// File: rtl/rf_wb_ld_align.sv
// Combinational load formatter: picks the byte/half selected by addr_lo and extends it.
// Half accesses use addr_lo[1] only; any funct3 outside LB/LH/LBU/LHU passes the word through.
module ld_align
  import rf_wb_pkg::*;
#(
  parameter int XLEN = WB_XLEN
) (
  input  logic [XLEN-1:0] data_i,
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      addr_lo_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  assign byte_s = 8'(data_i >> {addr_lo_i, 3'b000});
  assign half_s = 16'(data_i >> {addr_lo_i[1], 4'b0000});

  always_comb begin
    data_o = data_i;
    case (funct3_i)
      LB:      data_o = {{(XLEN-8){byte_s[7]}}, byte_s};
      LH:      data_o = {{(XLEN-16){half_s[15]}}, half_s};
      LBU:     data_o = {{(XLEN-8){1'b0}}, byte_s};
      LHU:     data_o = {{(XLEN-16){1'b0}}, half_s};
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/rf_wb.sv
// Writeback stage owning the register-file write port: ALU results win, buffered loads drain in bubbles.
// Optional macro WB_BYPASS_EN forwards the registered RF write onto the decode source operands.
module rf_wb
  import rf_wb_pkg::*;
#(
  parameter int XLEN  = WB_XLEN,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_issue_valid,
  input  logic [4:0]      ld_issue_rd,
  input  logic            ld_rsp_valid,
  output logic            ld_rsp_ready,
  input  logic [4:0]      ld_rsp_rd,
  input  logic [XLEN-1:0] ld_rsp_data,
  input  logic [2:0]      ld_rsp_funct3,
  input  logic [1:0]      ld_rsp_addr_lo,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [4:0]      chk_rd,
  output logic            busy_rs1,
  output logic            busy_rs2,
  output logic            busy_rd,
  output logic [4:0]      rf_rd,
  output logic            rf_write_e,
  output logic [XLEN-1:0] rf_write_d,
  input  logic [XLEN-1:0] rf_data1,
  input  logic [XLEN-1:0] rf_data2,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  ld_entry_t          fifo_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [REG_CNT-1:0] sb_q, sb_d;
  logic               rf_write_e_q, rf_write_e_d;
  logic               rf_ld_q, rf_ld_d;
  logic [4:0]         rf_rd_q, rf_rd_d;
  logic [XLEN-1:0]    rf_wdata_q, rf_wdata_d;

  ld_entry_t          head_s;
  logic [XLEN-1:0]    head_data_s;
  logic               not_empty_s;
  logic               push_s;
  logic               pop_s;

  assign ld_rsp_ready = (count_q < CNT_W'(DEPTH));
  assign not_empty_s  = (count_q != {CNT_W{1'b0}});
  assign push_s       = ld_rsp_valid && ld_rsp_ready;
  assign pop_s        = !alu_valid && not_empty_s;
  assign head_s       = fifo_q[rd_ptr_q];

  ld_align #(.XLEN(XLEN)) u_ld_align (
    .data_i    (head_s.data),
    .funct3_i  (head_s.funct3),
    .addr_lo_i (head_s.addr_lo),
    .data_o    (head_data_s)
  );

  // Buffer bookkeeping; pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
  end

  // Write select: ALU first, then the buffer head; x0 targets are consumed silently.
  always_comb begin
    rf_write_e_d = 1'b0;
    rf_ld_d      = 1'b0;
    rf_rd_d      = rf_rd_q;
    rf_wdata_d   = rf_wdata_q;
    if (alu_valid) begin
      rf_write_e_d = (alu_rd != 5'd0);
      rf_rd_d      = alu_rd;
      rf_wdata_d   = alu_data;
    end else if (not_empty_s) begin
      rf_write_e_d = (head_s.rd != 5'd0);
      rf_ld_d      = 1'b1;
      rf_rd_d      = head_s.rd;
      rf_wdata_d   = head_data_s;
    end else begin
      rf_write_e_d = 1'b0;
    end
  end

  // Pending-load scoreboard: clear on committed load write, then set on issue so set wins.
  always_comb begin
    sb_d = sb_q;
    if (rf_write_e_q && rf_ld_q) begin
      sb_d[rf_rd_q] = 1'b0;
    end else begin
      sb_d = sb_q;
    end
    if (ld_issue_valid && (ld_issue_rd != 5'd0)) begin
      sb_d[ld_issue_rd] = 1'b1;
    end else begin
      sb_d[0] = 1'b0;
    end
  end

  // Control state and registered RF write port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q     <= {PTR_W{1'b0}};
      rd_ptr_q     <= {PTR_W{1'b0}};
      count_q      <= {CNT_W{1'b0}};
      sb_q         <= {REG_CNT{1'b0}};
      rf_write_e_q <= 1'b0;
      rf_ld_q      <= 1'b0;
      rf_rd_q      <= 5'd0;
      rf_wdata_q   <= {XLEN{1'b0}};
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      sb_q         <= sb_d;
      rf_write_e_q <= rf_write_e_d;
      rf_ld_q      <= rf_ld_d;
      rf_rd_q      <= rf_rd_d;
      rf_wdata_q   <= rf_wdata_d;
    end
  end

  // Buffer storage; contents are meaningless while count_q says empty.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_q[wr_ptr_q] <= '{rd: ld_rsp_rd, data: ld_rsp_data,
                            funct3: ld_rsp_funct3, addr_lo: ld_rsp_addr_lo};
    end else begin
      fifo_q[wr_ptr_q] <= fifo_q[wr_ptr_q];
    end
  end

  assign rf_write_e = rf_write_e_q;
  assign rf_rd      = rf_rd_q;
  assign rf_write_d = rf_wdata_q;
  assign busy_rs1   = (rs1 != 5'd0) && sb_q[rs1];
  assign busy_rs2   = (rs2 != 5'd0) && sb_q[rs2];
  assign busy_rd    = (chk_rd != 5'd0) && sb_q[chk_rd];

`ifdef WB_BYPASS_EN
  // Covers the cycle where the RF is written and read at the same address.
  assign rs1_data = (rf_write_e_q && (rf_rd_q == rs1) && (rs1 != 5'd0)) ? rf_wdata_q : rf_data1;
  assign rs2_data = (rf_write_e_q && (rf_rd_q == rs2) && (rs2 != 5'd0)) ? rf_wdata_q : rf_data2;
`else
  assign rs1_data = rf_data1;
  assign rs2_data = rf_data2;
`endif

endmodule

// File: tb/tb_rf_wb.sv
// Randomised scoreboard bench for rf_wb against a queue-based behavioural model.
module tb_rf_wb;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid = 1'b0, ld_issue_valid = 1'b0, ld_rsp_valid = 1'b0;
  logic [4:0]  alu_rd = 5'd0, ld_issue_rd = 5'd0, ld_rsp_rd = 5'd0;
  logic [31:0] alu_data = 32'd0, ld_rsp_data = 32'd0, rf_data1 = 32'd0, rf_data2 = 32'd0;
  logic [2:0]  ld_rsp_funct3 = 3'd0;
  logic [1:0]  ld_rsp_addr_lo = 2'd0;
  logic [4:0]  rs1 = 5'd0, rs2 = 5'd0, chk_rd = 5'd0;
  logic        ld_rsp_ready, busy_rs1, busy_rs2, busy_rd, rf_write_e;
  logic [4:0]  rf_rd;
  logic [31:0] rf_write_d, rs1_data, rs2_data;

  rf_wb #(.XLEN(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_issue_valid(ld_issue_valid), .ld_issue_rd(ld_issue_rd),
    .ld_rsp_valid(ld_rsp_valid), .ld_rsp_ready(ld_rsp_ready), .ld_rsp_rd(ld_rsp_rd),
    .ld_rsp_data(ld_rsp_data), .ld_rsp_funct3(ld_rsp_funct3), .ld_rsp_addr_lo(ld_rsp_addr_lo),
    .rs1(rs1), .rs2(rs2), .chk_rd(chk_rd),
    .busy_rs1(busy_rs1), .busy_rs2(busy_rs2), .busy_rd(busy_rd),
    .rf_rd(rf_rd), .rf_write_e(rf_write_e), .rf_write_d(rf_write_d),
    .rf_data1(rf_data1), .rf_data2(rf_data2), .rs1_data(rs1_data), .rs2_data(rs2_data)
  );

  always #5 clk = ~clk;

  typedef struct { logic we; logic [4:0] rd; logic [31:0] d; } exp_t;
  typedef struct { logic [4:0] rd; logic [31:0] w; logic [2:0] f3; logic [1:0] a; } mld_t;

  exp_t        exp_q[$];
  mld_t        mq[$];
  logic [31:0] pend = 32'd0;
  logic        clr_v = 1'b0;
  logic [4:0]  clr_rd = 5'd0;
  logic        last_we = 1'b0;
  logic [4:0]  last_rd = 5'd0;
  logic [31:0] last_d = 32'd0;
  logic        just_reset = 1'b0;
  int          checks = 0;
  int          failures = 0;

  // Stimulus for the next step
  logic        s_rst, s_av, s_iv, s_rv;
  logic [4:0]  s_ard, s_ird, s_rrd, s_q1, s_q2, s_qd;
  logic [31:0] s_adata, s_rdata;
  logic [2:0]  s_f3;
  logic [1:0]  s_ra;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_align(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] a);
    logic [31:0] b, h;
    b = (w >> (8 * a)) & 32'hFF;
    h = (w >> (16 * (a / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
      3'd1:    return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] m_fwd(input logic [4:0] rs, input logic [31:0] rf);
`ifdef WB_BYPASS_EN
    if (last_we && last_rd == rs && rs != 5'd0) return last_d;
`endif
    return rf;
  endfunction

  task automatic clear_stim();
    s_rst = 1'b1; s_av = 1'b0; s_iv = 1'b0; s_rv = 1'b0;
    s_ard = 5'd0; s_ird = 5'd0; s_rrd = 5'd0; s_q1 = 5'd0; s_q2 = 5'd0; s_qd = 5'd0;
    s_adata = 32'd0; s_rdata = 32'd0; s_f3 = 3'd0; s_ra = 2'd0;
  endtask

  task automatic step();
    exp_t e;
    mld_t m;
    logic ready;
    @(negedge clk);
    #1;
    rst_n = s_rst; alu_valid = s_av; alu_rd = s_ard; alu_data = s_adata;
    ld_issue_valid = s_iv; ld_issue_rd = s_ird;
    ld_rsp_valid = s_rv; ld_rsp_rd = s_rrd; ld_rsp_data = s_rdata;
    ld_rsp_funct3 = s_f3; ld_rsp_addr_lo = s_ra;
    rs1 = s_q1; rs2 = s_q2; chk_rd = s_qd;
    rf_data1 = $urandom; rf_data2 = $urandom;
    #1;
    ready = (mq.size() < DEPTH);
    chk("ld_rsp_ready", {31'd0, ld_rsp_ready}, {31'd0, ready});
    chk("busy_rs1", {31'd0, busy_rs1}, {31'd0, s_q1 != 5'd0 && pend[s_q1]});
    chk("busy_rs2", {31'd0, busy_rs2}, {31'd0, s_q2 != 5'd0 && pend[s_q2]});
    chk("busy_rd", {31'd0, busy_rd}, {31'd0, s_qd != 5'd0 && pend[s_qd]});
    chk("rs1_data", rs1_data, m_fwd(s_q1, rf_data1));
    chk("rs2_data", rs2_data, m_fwd(s_q2, rf_data2));
    if (just_reset) begin
      chk("reset_rf_rd", {27'd0, rf_rd}, 32'd0);
      chk("reset_rf_write_d", rf_write_d, 32'd0);
      just_reset = 1'b0;
    end
    e = '{we: 1'b0, rd: 5'd0, d: 32'd0};
    if (!s_rst) begin
      mq.delete(); pend = 32'd0; clr_v = 1'b0; just_reset = 1'b1;
      last_we = 1'b0; last_rd = 5'd0; last_d = 32'd0;
    end else begin
      logic from_ld;
      from_ld = 1'b0;
      if (s_av) begin
        e.we = 1'b1; e.rd = s_ard; e.d = s_adata;
      end else if (mq.size() > 0) begin
        m = mq.pop_front();
        e.we = 1'b1; e.rd = m.rd; e.d = m_align(m.w, m.f3, m.a); from_ld = 1'b1;
      end
      if (s_rv && ready) mq.push_back('{rd: s_rrd, w: s_rdata, f3: s_f3, a: s_ra});
      if (clr_v) pend[clr_rd] = 1'b0;
      if (s_iv && s_ird != 5'd0) pend[s_ird] = 1'b1;
      e.we = e.we && (e.rd != 5'd0);
      clr_v = from_ld && e.we; clr_rd = e.rd;
      last_we = e.we;
      if (e.we) begin last_rd = e.rd; last_d = e.d; end
    end
    exp_q.push_back(e);
  endtask

  // Monitor: each cycle's registered write port against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rf_write_e", {31'd0, rf_write_e}, {31'd0, e.we});
        if (e.we && rf_write_e) begin
          chk("rf_rd", {27'd0, rf_rd}, {27'd0, e.rd});
          chk("rf_write_d", rf_write_d, e.d);
        end
      end
    end
  end

  task automatic idle(input int n, input logic [4:0] q);
    for (int i = 0; i < n; i++) begin
      clear_stim(); s_q1 = q; s_q2 = q; s_qd = q; step();
    end
  endtask

  task automatic rand_steps(input int n);
    logic [2:0] f3s [8];
    f3s = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    for (int i = 0; i < n; i++) begin
      clear_stim();
      s_av = ($urandom_range(0, 99) < 45);
      s_ard = 5'($urandom_range(0, 31)); s_adata = $urandom;
      s_iv = ($urandom_range(0, 99) < 30); s_ird = 5'($urandom_range(0, 31));
      s_rv = ($urandom_range(0, 99) < 50); s_rrd = 5'($urandom_range(0, 31));
      s_rdata = $urandom; s_f3 = f3s[$urandom_range(0, 7)]; s_ra = 2'($urandom_range(0, 3));
      if (s_f3 == 3'd1 || s_f3 == 3'd5) s_ra[0] = 1'b0;
      s_q1 = 5'($urandom_range(0, 31)); s_q2 = 5'($urandom_range(0, 31));
      s_qd = 5'($urandom_range(0, 31));
      step();
    end
  endtask

  initial begin
    clear_stim(); s_rst = 1'b0; step(); step();
    // T1: plain ALU write
    clear_stim(); s_av = 1'b1; s_ard = 5'd5; s_adata = 32'h1234; step();
    idle(1, 5'd5);
    // T2: load pending on x7, LB byte 3 sign-extends, busy clears after the write
    clear_stim(); s_iv = 1'b1; s_ird = 5'd7; step();
    idle(1, 5'd7);
    clear_stim(); s_rv = 1'b1; s_rrd = 5'd7; s_rdata = 32'h80FF_FFFF; s_f3 = 3'd0; s_ra = 2'd3;
    s_q1 = 5'd7; step();
    idle(4, 5'd7);
    // T3: ALU held 4 cycles while three responses try to enter a 2-deep buffer
    for (int i = 0; i < 4; i++) begin
      clear_stim(); s_av = 1'b1; s_ard = 5'(20 + i); s_adata = 32'(i);
      s_rv = 1'b1; s_rrd = (i < 2) ? 5'(i + 1) : 5'd3; s_rdata = 32'hCAFE_0000 + 32'(i); s_f3 = 3'd2;
      step();
    end
    idle(4, 5'd1);
    // T4: x0 destinations never write
    clear_stim(); s_av = 1'b1; s_ard = 5'd0; s_adata = 32'hDEAD; s_rv = 1'b1; s_rrd = 5'd0;
    s_rdata = 32'h1111_2222; s_f3 = 3'd2; step();
    idle(3, 5'd0);
    // T5: reset with buffered responses and pending bits
    for (int i = 0; i < 3; i++) begin
      clear_stim(); s_iv = 1'b1; s_ird = 5'(10 + i); s_av = 1'b1; s_ard = 5'd30; s_adata = 32'(i);
      s_rv = (i < 2); s_rrd = 5'(10 + i); s_rdata = $urandom; s_f3 = 3'd4; s_ra = 2'(i);
      step();
    end
    clear_stim(); s_rst = 1'b0; s_q1 = 5'd10; step();
    for (int i = 0; i < 3; i++) idle(1, 5'(10 + i));
    // T6: forwarding window, then x0 source
    clear_stim(); s_av = 1'b1; s_ard = 5'd9; s_adata = 32'hA5; step();
    clear_stim(); s_q1 = 5'd9; s_q2 = 5'd9; step();
    clear_stim(); s_av = 1'b1; s_ard = 5'd0; s_adata = 32'hA5; step();
    clear_stim(); s_q1 = 5'd0; step();
    rand_steps(600);
    clear_stim(); s_rst = 1'b0; step();
    rand_steps(600);
    idle(6, 5'd0);
    @(negedge clk);
    #2;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
